// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: peripheral window decode and FSM state encoding.
package mem_arbiter_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the priority pointer moves only when a transaction completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       last,
  input  logic       advance,
  output logic [1:0] grant
);

  logic favour_m1;

  // After a completion the master that did not win last time gets the tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      favour_m1 <= 1'b0;
    end else if (advance) begin
      favour_m1 <= ~last;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = favour_m1 ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: round-robin grant, IDLE/ACCESS/RESP transaction,
// decode between data_ram and the peripheral window, misalignment error reporting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          cpu_stall_o,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          per_we,
  output logic [AW-1:0] per_addr,
  output logic [DW-1:0] per_wdata,
  input  logic [DW-1:0] per_rdata
);

  state_t        state;
  logic          win, cap_we, cap_per, cap_err;
  logic          ram_we_q, per_we_q;
  logic [1:0]    ack_q, err_q, grant;
  logic          sel_we, sel_per, sel_mis;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, resp_data;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req, m0_req}),
    .last    (win),
    .advance (state == RESP),
    .grant   (grant)
  );

  always_comb begin
    sel_addr  = grant[1] ? m1_addr  : m0_addr;
    sel_wdata = grant[1] ? m1_wdata : m0_wdata;
    sel_we    = grant[1] ? m1_we    : m0_we;
    sel_per   = (sel_addr & AW'(PERIPH_MASK)) == AW'(PERIPH_BASE);
    sel_mis   = sel_addr[1:0] != 2'b00;
    // Writes and misaligned accesses return zero read data.
    resp_data = '0;
    if (!cap_we && !cap_err) begin
      resp_data = cap_per ? per_rdata : ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win       <= 1'b0;
      cap_we    <= 1'b0;
      cap_per   <= 1'b0;
      cap_err   <= 1'b0;
      ram_we_q  <= 1'b0;
      per_we_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      per_addr  <= '0;
      per_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      ram_we_q <= 1'b0;
      per_we_q <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            win     <= grant[1];
            cap_we  <= sel_we;
            cap_per <= sel_per;
            cap_err <= sel_mis;
            if (sel_per) begin
              per_addr  <= sel_addr;
              per_wdata <= sel_wdata;
            end else begin
              ram_addr  <= sel_addr;
              ram_wdata <= sel_wdata;
            end
            ram_we_q <= sel_we & ~sel_mis & ~sel_per;
            per_we_q <= sel_we & ~sel_mis & sel_per;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (win) begin
            m1_rdata <= resp_data;
          end else begin
            m0_rdata <= resp_data;
          end
          ack_q <= win ? 2'b10 : 2'b01;
          err_q <= cap_err ? (win ? 2'b10 : 2'b01) : 2'b00;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_we      = ram_we_q & ~rst;
  assign per_we      = per_we_q & ~rst;
  assign m0_ack      = ack_q[0] & ~rst;
  assign m1_ack      = ack_q[1] & ~rst;
  assign m0_err      = err_q[0] & ~rst;
  assign m1_err      = err_q[1] & ~rst;
  assign cpu_stall_o = m0_req & ~m0_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order,
// ack cycles, read data and downstream writes; a monitor compares every cycle.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } tx_t;
  typedef struct { int m; bit err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { bit per; logic [31:0] addr; logic [31:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_ack, m0_err, m1_ack, m1_err, cpu_stall_o, ram_we, per_we;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata, per_addr, per_wdata, per_rdata;

  logic [31:0] ram_mem [64] = '{default: '0};
  logic [31:0] per_mem [64] = '{default: '0};
  logic [31:0] mdl_ram [64] = '{default: '0};
  logic [31:0] mdl_per [64] = '{default: '0};

  tx_t   txq0[$], txq1[$];
  resp_t sb[$];
  wr_t   wq[$];
  int    checks = 0, passes = 0, cyc = 0, fav = 0;
  logic [31:0] hold_rd0 = '0, hold_rd1 = '0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .cpu_stall_o(cpu_stall_o),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple asynchronous-read memories standing in for data_ram and the peripheral.
  assign ram_rdata = ram_mem[ram_addr[7:2]];
  assign per_rdata = per_mem[per_addr[7:2]];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[7:2]] <= ram_wdata;
    if (per_we) per_mem[per_addr[7:2]] <= per_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic tx_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    tx_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic tx_t gen_tx();
    int unsigned k = $urandom_range(0, 9);
    logic [31:0] off = 32'($urandom_range(0, 15)) << 2;
    logic [31:0] a;
    if (k <= 4)      a = off;
    else if (k <= 7) a = 32'h4000_0000 | off;
    else if (k == 8) a = 32'h4001_0000 | off;
    else             a = ($urandom_range(0, 1) != 0 ? 32'h4000_0000 : 32'h0) | off | 32'($urandom_range(1, 3));
    return mk($urandom_range(0, 1) != 0, a, $urandom);
  endfunction

  // Transaction-level model: serialise both masters' lists by round-robin,
  // one completion every 3 cycles starting 2 cycles after issue.
  task automatic predict(input int c);
    int i0 = 0, i1 = 0, k = 0, m;
    tx_t t; resp_t r; wr_t w; bit per;
    while (i0 < txq0.size() || i1 < txq1.size()) begin
      if (i0 < txq0.size() && i1 < txq1.size()) m = fav;
      else m = (i0 < txq0.size()) ? 0 : 1;
      if (m == 0) begin t = txq0[i0]; i0++; end
      else begin t = txq1[i1]; i1++; end
      r.m = m; r.cyc = c + 2 + 3 * k; r.err = t.addr[1:0] != 2'b00; r.rdata = '0;
      per = (t.addr & 32'hFFFF_0000) == 32'h4000_0000;
      if (!r.err) begin
        if (t.we) begin
          if (per) mdl_per[t.addr[7:2]] = t.wdata;
          else     mdl_ram[t.addr[7:2]] = t.wdata;
          w.per = per; w.addr = t.addr; w.data = t.wdata;
          wq.push_back(w);
        end else begin
          r.rdata = per ? mdl_per[t.addr[7:2]] : mdl_ram[t.addr[7:2]];
        end
      end
      sb.push_back(r);
      fav = 1 - m;
      k++;
    end
  endtask

  task automatic drive0();
    if (txq0.size() > 0) begin
      m0_req = 1'b1; m0_we = txq0[0].we; m0_addr = txq0[0].addr; m0_wdata = txq0[0].wdata;
    end else begin
      m0_req = 1'b0; m0_we = 1'b0;
    end
  endtask

  task automatic drive1();
    if (txq1.size() > 0) begin
      m1_req = 1'b1; m1_we = txq1[0].we; m1_addr = txq1[0].addr; m1_wdata = txq1[0].wdata;
    end else begin
      m1_req = 1'b0; m1_we = 1'b0;
    end
  endtask

  // Called just after a rising edge with the arbiter idle.
  task automatic run_round();
    int budget = 3 * (txq0.size() + txq1.size()) + 10;
    predict(cyc);
    drive0();
    drive1();
    while ((txq0.size() > 0 || txq1.size() > 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (m0_ack && txq0.size() > 0) begin void'(txq0.pop_front()); drive0(); end
      if (m1_ack && txq1.size() > 0) begin void'(txq1.pop_front()); drive1(); end
    end
    check1("round_done", budget > 0, 1'b1);
    txq0.delete(); txq1.delete();
    drive0(); drive1();
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("writes_drained", wq.size(), 0);
    sb.delete(); wq.delete();
  endtask

  always @(negedge clk) begin : monitor
    bit e0, e1, er0, er1;
    wr_t w;
    if (rst) begin
      check1("rst_ram_we", ram_we, 1'b0);
      check1("rst_per_we", per_we, 1'b0);
      check1("rst_m0_ack", m0_ack, 1'b0);
      check1("rst_m1_ack", m1_ack, 1'b0);
      hold_rd0 = '0; hold_rd1 = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("ack_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      e0 = sb.size() > 0 && sb[0].cyc == cyc && sb[0].m == 0;
      e1 = sb.size() > 0 && sb[0].cyc == cyc && sb[0].m == 1;
      er0 = e0 && sb[0].err;
      er1 = e1 && sb[0].err;
      if (e0) hold_rd0 = sb[0].rdata;
      if (e1) hold_rd1 = sb[0].rdata;
      if (e0 || e1) void'(sb.pop_front());
      check1("m0_ack", m0_ack, e0);
      check1("m1_ack", m1_ack, e1);
      check1("m0_err", m0_err, er0);
      check1("m1_err", m1_err, er1);
      check("m0_rdata", m0_rdata, hold_rd0);
      check("m1_rdata", m1_rdata, hold_rd1);
      check1("cpu_stall", cpu_stall_o, m0_req & ~e0);
      check1("dual_strobe", ram_we & per_we, 1'b0);
      if (ram_we || per_we) begin
        check1("strobe_expected", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check1("strobe_target", per_we, w.per);
          check("strobe_addr", per_we ? per_addr : ram_addr, w.addr);
          check("strobe_data", per_we ? per_wdata : ram_wdata, w.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_m0_rdata", m0_rdata, 32'h0);
    check("reset_m1_rdata", m1_rdata, 32'h0);
    check1("reset_stall", cpu_stall_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie with both held: m0, m1, m0, m1 with acks 3 cycles apart.
    txq0.push_back(mk(1, 32'h30, 32'hA5A5_0001));
    txq0.push_back(mk(0, 32'h34, 32'h0));
    txq1.push_back(mk(0, 32'h30, 32'h0));
    txq1.push_back(mk(0, 32'h38, 32'h0));
    run_round();

    // m0 write then read back from data_ram.
    txq0.push_back(mk(1, 32'h10, 32'hDEADBEEF));
    run_round();
    txq0.push_back(mk(0, 32'h10, 32'h0));
    run_round();

    // m1 write into the peripheral window, then read it back.
    txq1.push_back(mk(1, 32'h4000_0004, 32'h0BAD_F00D));
    txq1.push_back(mk(0, 32'h4000_0004, 32'h0));
    run_round();

    // Misaligned read and write: error pulse, zero data, no strobe.
    txq0.push_back(mk(0, 32'h13, 32'h0));
    txq0.push_back(mk(1, 32'h13, 32'h1234_5678));
    run_round();

    for (int r = 0; r < 40; r++) begin
      int n0 = $urandom_range(0, 3);
      int n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) txq0.push_back(gen_tx());
      for (int i = 0; i < n1; i++) txq1.push_back(gen_tx());
      run_round();
    end

    // Leave the pointer favouring m1, then abort a write with reset during ACCESS.
    txq0.push_back(mk(0, 32'h24, 32'h0));
    run_round();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0; m0_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fav = 0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_m0_rdata", m0_rdata, 32'h0);
    check("abort_mem", ram_mem[8], mdl_ram[8]);
    txq0.push_back(mk(0, 32'h20, 32'h0));
    txq1.push_back(mk(0, 32'h24, 32'h0));
    run_round();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
  - AW, 32, address width.
  - DW, 32, data width.
REQ-002 The module SHALL have these ports (name  direction  width  meaning):
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  synchronous, active-high reset.
  - m0_req / m0_we  in  1 / 1  CPU memory-stage request and write enable.
  - m0_addr / m0_wdata  in  AW / DW  CPU address and write data.
  - m0_ack / m0_err  out  1 / 1  CPU completion pulse and alignment-error pulse.
  - m0_rdata  out  DW  CPU read data.
  - m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same widths as m0_*  second master (program loader/DMA).
  - cpu_stall_o  out  1  equals m0_req & ~m0_ack.
  - ram_we / ram_addr / ram_wdata  out  1 / AW / DW  data_ram write strobe, address, write data.
  - ram_rdata  in  DW  data_ram read data.
  - per_we / per_addr / per_wdata  out  1 / AW / DW  peripheral write strobe, address, write data.
  - per_rdata  in  DW  peripheral read data.

Function
REQ-003 FSM SHALL have states IDLE, ACCESS, RESP; each transaction takes exactly IDLE->ACCESS->RESP->IDLE, so ack is asserted 2 cycles after the request is sampled in IDLE.
REQ-004 In IDLE with any req high, the arbiter SHALL pick the winner, register addr/we/wdata/target/error and go to ACCESS; with no req it SHALL stay in IDLE.
REQ-005 Winner selection SHALL be 2-way round-robin: single requester wins; on a tie the master not granted last wins; the priority pointer SHALL favour m0 after reset and toggle only on completed transactions.
REQ-006 Target decode SHALL be: peripheral when (addr & PERIPH_MASK) == PERIPH_BASE (0x4000_0000, mask 0xFFFF_0000), otherwise data_ram.
REQ-007 Misaligned accesses (addr[1:0] != 0) SHALL drive no downstream strobe; in RESP they SHALL pulse err together with ack, with rdata = 0.
REQ-008 In ACCESS the selected target's addr/wdata SHALL be driven from registers, and its we SHALL be high for exactly that one cycle if the access is a write; the other target's we SHALL stay 0.
REQ-009 At the end of ACCESS the selected target's rdata SHALL be registered; in RESP the winner's ack SHALL pulse for one cycle carrying that rdata. Writes SHALL return rdata = 0.
REQ-010 The loser's ack and err SHALL stay 0, and all rdata outputs SHALL hold their value outside RESP.
REQ-011 A master SHALL hold req and its fields stable until ack; the arbiter SHALL ignore field changes after capture.
REQ-012 A req still high in the cycle after ack SHALL be treated as a new request in IDLE; back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-013 Idle downstream outputs: ram_we = per_we = 0; addr/wdata buses SHALL hold their last registered value.

Reset
REQ-014 While rst is high at a clock edge: state SHALL become IDLE, the priority pointer SHALL favour m0, and all captured registers and rdata outputs SHALL be 0.
REQ-015 ram_we, per_we, m0_ack, m1_ack, m0_err and m1_err SHALL be gated by ~rst, so rst asserted during ACCESS or RESP suppresses the strobe or ack in that same cycle; the aborted transaction SHALL never complete.

Structure
REQ-016 PERIPH_BASE, PERIPH_MASK and the state encodings SHALL live in the shared defines include used by the CPU and SOPC.
REQ-017 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: req[1:0], last, advance; output: onehot grant).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - m0 write 0x0000_0010 = 0xDEADBEEF, then m0 read -> ram_we high exactly 1 cycle; read ack 2 cycles after sampling with rdata 0xDEADBEEF.
  - m0 and m1 req asserted in the same cycle, both held -> grants m0, m1, m0, m1; acks 3 cycles apart; cpu_stall_o high while m0 waits.
  - m1 write to 0x4000_0004 -> per_we pulses once with per_wdata correct; ram_we stays 0.
  - m0 read at 0x0000_0013 -> m0_err and m0_ack pulse together, rdata 0, no strobes.
  - rst asserted in the ACCESS cycle of a write -> no ram_we pulse, no ack, state IDLE, next tie grants m0.
